// File: rtl/m_rect_fill.sv
// m_rect_fill: queued rectangle fill engine feeding the 256x256x16 video memory.
// Commands land in a small FIFO, get clipped to the visible area, and are then
// written one pixel per clock in raster order as {y, x} addressed vmem writes.
module m_rect_fill #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = 240,
  parameter int unsigned SCREEN_H   = 240
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_cmd_valid,
  output logic        w_cmd_ready,
  input  logic [7:0]  w_cmd_x0,
  input  logic [7:0]  w_cmd_y0,
  input  logic [7:0]  w_cmd_x1,
  input  logic [7:0]  w_cmd_y1,
  input  logic [15:0] w_cmd_color,
  output logic        w_we,
  output logic [15:0] w_wadr,
  output logic [15:0] w_wdata,
  output logic        w_busy,
  output logic        w_done
);

  localparam int unsigned AW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [7:0]    XMAX     = 8'(SCREEN_W - 1);
  localparam logic [7:0]    YMAX     = 8'(SCREEN_H - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  // FIFO entry layout: {x0, y0, x1, y1, color}
  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          push;
  logic          pop;

  logic [1:0]  state;
  logic [47:0] cmd;
  logic [7:0]  x, y, x_start, xe, ye;
  logic [15:0] color;
  logic [7:0]  ld_xe, ld_ye;
  logic        ld_empty;

  assign push = w_cmd_valid & w_cmd_ready;
  assign pop  = (state == S_IDLE) && (cnt != '0);

  // FIFO occupancy after this edge
  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // FIFO storage write
  always_ff @(posedge w_clk) begin
    if (push) fifo_mem[wr_ptr] <= {w_cmd_x0, w_cmd_y0, w_cmd_x1, w_cmd_y1, w_cmd_color};
  end

  // FIFO pointers, count, and the registered ready/busy flags
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      w_cmd_ready <= 1'b0;
      w_busy      <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      w_cmd_ready <= (cnt_nxt != FULL_CNT);
      // pop term keeps busy high across the IDLE->LOAD hand-off when the
      // last queued entry is being taken out
      w_busy      <= (cnt_nxt != '0) || (state != S_IDLE) || pop;
    end
  end

  // Clip the popped command to the visible area and flag empty rectangles
  always_comb begin
    ld_xe    = (cmd[31:24] > XMAX) ? XMAX : cmd[31:24];
    ld_ye    = (cmd[23:16] > YMAX) ? YMAX : cmd[23:16];
    ld_empty = (cmd[47:40] > ld_xe) || (cmd[39:32] > ld_ye) ||
               (cmd[47:40] > XMAX)  || (cmd[39:32] > YMAX);
  end

  // Control FSM and registered write-port outputs
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state   <= S_IDLE;
      w_we    <= 1'b0;
      w_wadr  <= '0;
      w_wdata <= '0;
      w_done  <= 1'b0;
    end else begin
      w_we   <= 1'b0;
      w_done <= 1'b0;
      case (state)
        S_IDLE: if (pop) state <= S_LOAD;
        S_LOAD: begin
          if (ld_empty) begin
            state  <= S_IDLE;
            w_done <= 1'b1;
          end else begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          w_we    <= 1'b1;
          w_wadr  <= {y, x};
          w_wdata <= color;
          if (x == xe && y == ye) begin
            state  <= S_IDLE;
            w_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: command latch, clipped bounds and raster position
  always_ff @(posedge w_clk) begin
    case (state)
      S_IDLE: if (pop) cmd <= fifo_mem[rd_ptr];
      S_LOAD: begin
        x       <= cmd[47:40];
        y       <= cmd[39:32];
        x_start <= cmd[47:40];
        xe      <= ld_xe;
        ye      <= ld_ye;
        color   <= cmd[15:0];
      end
      S_FILL: begin
        // compare before increment so 8-bit coordinates never wrap
        if (x == xe) begin
          x <= x_start;
          if (y != ye) y <= y + 8'd1;
        end else begin
          x <= x + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m_rect_fill.sv
// Testbench for m_rect_fill: fixed vector table, randomized command streams,
// backpressure, reset mid-fill and a full-screen fill, all checked against a
// pixel-list reference model built from clipped rectangle arithmetic.
module tb_m_rect_fill;

  localparam int SW = 240;
  localparam int SH = 240;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_cmd_valid = 1'b0;
  logic        w_cmd_ready;
  logic [7:0]  w_cmd_x0 = '0, w_cmd_y0 = '0, w_cmd_x1 = '0, w_cmd_y1 = '0;
  logic [15:0] w_cmd_color = '0;
  logic        w_we;
  logic [15:0] w_wadr;
  logic [15:0] w_wdata;
  logic        w_busy;
  logic        w_done;

  m_rect_fill #(.FIFO_DEPTH(4), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready),
    .w_cmd_x0(w_cmd_x0), .w_cmd_y0(w_cmd_y0), .w_cmd_x1(w_cmd_x1), .w_cmd_y1(w_cmd_y1),
    .w_cmd_color(w_cmd_color),
    .w_we(w_we), .w_wadr(w_wadr), .w_wdata(w_wdata), .w_busy(w_busy), .w_done(w_done)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [7:0]  x0, y0, x1, y1;
    logic [15:0] col;
  } cmd_t;

  typedef struct {
    logic [7:0]  x0, y0, x1, y1;
    logic [15:0] col;
    int          n;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int oob = 0;
  int n_acc = 0;
  int saw_full = 0;
  int acc_before_full = -1;

  logic [31:0] got[$];
  int          got_cyc[$];
  int          done_cyc[$];
  cmd_t        sent[$];

  always @(posedge w_clk) cyc <= cyc + 1;

  // Write-port monitor
  always @(negedge w_clk) begin
    if (w_we) begin
      got.push_back({w_wdata, w_wadr});
      got_cyc.push_back(cyc);
      if (w_wadr[7:0] > 8'd239 || w_wadr[15:8] > 8'd239) oob++;
    end
    if (w_done) done_cyc.push_back(cyc);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    done_cyc.delete();
    sent.delete();
  endtask

  task automatic push(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                      input logic [7:0] y1, input logic [15:0] col, output int acc);
    @(negedge w_clk);
    w_cmd_x0 = x0; w_cmd_y0 = y0; w_cmd_x1 = x1; w_cmd_y1 = y1; w_cmd_color = col;
    w_cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000; i++) begin
      if (w_cmd_ready) begin
        @(posedge w_clk);
        #1;
        acc = cyc;
        break;
      end
      if (saw_full == 0) begin
        saw_full = 1;
        acc_before_full = n_acc;
      end
      @(negedge w_clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL push_accept: actual not accepted, required accepted");
    end else begin
      n_acc++;
      sent.push_back('{x0, y0, x1, y1, col});
    end
  endtask

  task automatic drop_valid();
    @(negedge w_clk);
    w_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge w_clk);
      if (!w_busy) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_idle"}, ok, 1);
    repeat (4) @(negedge w_clk);
  endtask

  // Reference: every sent rectangle, clipped to the screen, in raster order.
  task automatic check_model(input string nm);
    logic [31:0] exp[$];
    int mism;
    foreach (sent[k]) begin
      for (int y = int'(sent[k].y0); y <= int'(sent[k].y1) && y < SH; y++)
        for (int x = int'(sent[k].x0); x <= int'(sent[k].x1) && x < SW; x++)
          exp.push_back({sent[k].col, 8'(y), 8'(x)});
    end
    chk({nm, "_nwrites"}, got.size(), exp.size());
    mism = 0;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      if (got[i] !== exp[i]) begin
        if (mism == 0)
          $display("FAIL %s_pixel[%0d]: actual %0h, required %0h", nm, i, got[i], exp[i]);
        mism++;
      end
    end
    chk({nm, "_pixel_mismatches"}, mism, 0);
    chk({nm, "_ndone"}, done_cyc.size(), sent.size());
  endtask

  vec_t tbl[8];

  initial begin
    int acc, found, nbrk, bad, dm, base, dbase, idx;
    int rx0, ry0, rx1, ry1;
    logic [31:0] w;

    tbl[0] = '{8'd10,  8'd20,  8'd11,  8'd21,  16'hF800, 4, 16'h140A, 16'h150B};
    tbl[1] = '{8'd238, 8'd0,   8'd250, 8'd0,   16'h07E0, 2, 16'h00EE, 16'h00EF};
    tbl[2] = '{8'd240, 8'd5,   8'd245, 8'd6,   16'h1234, 0, 16'h0000, 16'h0000};
    tbl[3] = '{8'd5,   8'd5,   8'd4,   8'd9,   16'hABCD, 0, 16'h0000, 16'h0000};
    tbl[4] = '{8'd239, 8'd239, 8'd255, 8'd255, 16'h5555, 1, 16'hEFEF, 16'hEFEF};
    tbl[5] = '{8'd0,   8'd0,   8'd0,   8'd0,   16'hFFFF, 1, 16'h0000, 16'h0000};
    tbl[6] = '{8'd3,   8'd250, 8'd5,   8'd255, 16'h0F0F, 0, 16'h0000, 16'h0000};
    tbl[7] = '{8'd0,   8'd7,   8'd2,   8'd7,   16'h1111, 3, 16'h0700, 16'h0702};

    // Reset values
    repeat (3) @(negedge w_clk);
    chk("rst_we", w_we, 0);
    chk("rst_wadr", w_wadr, 0);
    chk("rst_wdata", w_wdata, 0);
    chk("rst_done", w_done, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_ready", w_cmd_ready, 0);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    chk("ready_after_rst", w_cmd_ready, 1);

    // Table of single commands
    for (int t = 0; t < 8; t++) begin
      clear_log();
      push(tbl[t].x0, tbl[t].y0, tbl[t].x1, tbl[t].y1, tbl[t].col, acc);
      @(negedge w_clk);
      w_cmd_valid = 1'b0;
      chk($sformatf("t%0d_busy_rise", t), w_busy, 1);
      found = 0;
      for (int i = 0; i < 50; i++) begin
        if (w_done) begin
          found = 1;
          break;
        end
        @(negedge w_clk);
      end
      chk($sformatf("t%0d_done_seen", t), found, 1);
      chk($sformatf("t%0d_busy_at_done", t), w_busy, 1);
      @(negedge w_clk);
      chk($sformatf("t%0d_busy_fall", t), w_busy, 0);
      if (tbl[t].n > 0) begin
        chk($sformatf("t%0d_we_after", t), w_we, 0);
        chk($sformatf("t%0d_wadr_hold", t), w_wadr, tbl[t].last);
      end
      repeat (4) @(negedge w_clk);
      chk($sformatf("t%0d_count", t), got.size(), tbl[t].n);
      chk($sformatf("t%0d_done_count", t), done_cyc.size(), 1);
      if (tbl[t].n > 0 && got.size() > 0 && done_cyc.size() > 0) begin
        w = got[0];
        chk($sformatf("t%0d_first_adr", t), w[15:0], tbl[t].first);
        w = got[got.size() - 1];
        chk($sformatf("t%0d_last_adr", t), w[15:0], tbl[t].last);
        chk($sformatf("t%0d_latency", t), got_cyc[0] - acc, 3);
        chk($sformatf("t%0d_done_on_last", t), done_cyc[0], got_cyc[got_cyc.size() - 1]);
      end
      check_model($sformatf("t%0d", t));
    end

    // Randomized command stream
    clear_log();
    for (int k = 0; k < 24; k++) begin
      rx0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(224, 255)) : int'($urandom_range(0, 255));
      ry0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(224, 255)) : int'($urandom_range(0, 255));
      rx1 = rx0 + int'($urandom_range(0, 15));
      ry1 = ry0 + int'($urandom_range(0, 7));
      if (rx1 > 255) rx1 = 255;
      if (ry1 > 255) ry1 = 255;
      if ($urandom_range(0, 7) == 0 && rx0 > 0) rx1 = rx0 - 1;
      push(8'(rx0), 8'(ry0), 8'(rx1), 8'(ry1), 16'($urandom), acc);
    end
    drop_valid();
    wait_idle("rand", 20000);
    check_model("rand");

    // Backpressure: six 16x16 commands presented back to back
    clear_log();
    saw_full = 0;
    acc_before_full = -1;
    n_acc = 0;
    for (int k = 0; k < 6; k++)
      push(8'(32 * k), 8'(8 * k), 8'(32 * k + 15), 8'(8 * k + 15), 16'(16'hA000 + k), acc);
    drop_valid();
    wait_idle("bp", 5000);
    chk("bp_ready_dropped", saw_full, 1);
    chk("bp_accepts_before_full", acc_before_full, 5);
    check_model("bp");
    nbrk = 0;
    bad = 0;
    for (int i = 1; i < got_cyc.size(); i++) begin
      if (got_cyc[i] - got_cyc[i - 1] != 1) begin
        nbrk++;
        if (got_cyc[i] - got_cyc[i - 1] != 3) bad++;
      end
    end
    chk("bp_gap_count", nbrk, 5);
    chk("bp_gap_bad", bad, 0);
    dm = 0;
    for (int k = 0; k < 6; k++) begin
      idx = 256 * (k + 1) - 1;
      if (idx < got_cyc.size() && k < done_cyc.size()) begin
        if (done_cyc[k] != got_cyc[idx]) dm++;
      end else begin
        dm++;
      end
    end
    chk("bp_done_alignment", dm, 0);

    // Reset in the middle of a large fill with two commands queued
    clear_log();
    push(8'd0, 8'd0, 8'd239, 8'd239, 16'hC0DE, acc);
    push(8'd1, 8'd1, 8'd2, 8'd2, 16'h0101, acc);
    push(8'd3, 8'd3, 8'd4, 8'd4, 16'h0202, acc);
    drop_valid();
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (got.size() >= 100) begin
        found = 1;
        break;
      end
      @(negedge w_clk);
    end
    chk("mid_reached_100", found, 1);
    w_rst_n = 1'b0;
    @(negedge w_clk);
    chk("mid_rst_we", w_we, 0);
    chk("mid_rst_busy", w_busy, 0);
    chk("mid_rst_ready", w_cmd_ready, 0);
    chk("mid_rst_done", w_done, 0);
    chk("mid_rst_wadr", w_wadr, 0);
    w_rst_n = 1'b1;
    base = got.size();
    dbase = done_cyc.size();
    @(negedge w_clk);
    chk("mid_ready_back", w_cmd_ready, 1);
    repeat (300) @(negedge w_clk);
    chk("mid_no_writes", got.size(), base);
    chk("mid_no_done", done_cyc.size(), dbase);
    chk("mid_busy_low", w_busy, 0);
    clear_log();
    push(8'd100, 8'd100, 8'd101, 8'd100, 16'hBEEF, acc);
    drop_valid();
    wait_idle("post_rst", 200);
    check_model("post_rst");

    // Full screen, requested beyond the visible area
    clear_log();
    push(8'd0, 8'd0, 8'd255, 8'd255, 16'h001F, acc);
    drop_valid();
    wait_idle("full", 60000);
    check_model("full");
    if (got.size() > 0) begin
      w = got[got.size() - 1];
      chk("full_last_adr", w[15:0], 16'hEFEF);
    end
    chk("no_offscreen_writes", oob, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
